cam_pixel_writer: RTL and testbench
===================================

Name: cam_pixel_writer

Overview:
- Capture-side counterpart of the display read path: takes the OV5640 8-bit DVP stream (VSYNC/HREF/DATA), assembles RGB565 pixels, and 2:1 decimates in X and Y.
- Emits write strobes and data to one write port of the 4-port SDRAM controller.
- Stored word layout: R in [4:0], G in [10:5], B in [15:11]. This is the layout the display path unpacks.
- Runs entirely in the camera pixel clock domain. The SDRAM write FIFO provides the clock crossing.

Parameters:
- SRC_H, 640, camera active pixels per line.
- SRC_V, 480, camera active lines per frame.
- DECIM, 1, 1 keeps even pixels/lines only (output 320x240); 0 keeps all (output SRC_H x SRC_V).
- SKIP_FRAMES, 10, complete frames discarded after reset while the sensor settles (0..255).
- VS_POL, 1, 1 = CAM_VSYNC active high during vertical blanking; 0 = active low.

Ports:
- clk  in  1  camera PCLK; all logic samples on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- CAM_VSYNC  in  1  frame sync; polarity set by VS_POL.
- CAM_HREF  in  1  line valid; byte qualifier, high during active bytes.
- CAM_DATA  in  8  pixel byte; byte 0 = {R5,G[5:3]}, byte 1 = {G[2:0],B5}.
- Write_DATA  out  16  packed pixel {B5,G6,R5} as {[15:11],[10:5],[4:0]}.
- Write_EN  out  1  one-cycle strobe; Write_DATA is valid while high.
- Frame_Start  out  1  one-cycle pulse before the first write of an accepted frame (clears the SDRAM write address).
- Frame_Done  out  1  one-cycle pulse when an accepted frame ends.
- Frame_Err  out  1  pixel count of the last accepted frame was not OUT_H*OUT_V; updated at Frame_Done.
- Capturing  out  1  high while in ACTIVE state.

Behaviour:
- Derived sizes: OUT_H = DECIM ? SRC_H/2 : SRC_H; OUT_V likewise from SRC_V.
- Reset values: all outputs 0, state WAIT_SYNC, skip counter 0, byte phase 0, x/y counters 0.
- Sync input: vs = CAM_VSYNC XNOR VS_POL (1 = blanking). The inputs are sampled into one register stage. Edge detection uses the registered vs and its previous value.

State machine:
- WAIT_SYNC: wait for a falling edge of vs (blanking to active), then go to SKIP. A frame already in progress at reset is never captured.
- SKIP:
  - On each vs rising edge, increment the skip counter.
  - When the count reaches SKIP_FRAMES, go to ARMED.
  - If SKIP_FRAMES = 0, go directly from WAIT_SYNC to ARMED.
- ARMED: on a vs falling edge, pulse Frame_Start and clear x, y, byte phase and the pixel counter. Go to ACTIVE.
- ACTIVE:
  - Bytes are accepted while HREF is high. Phase 0 latches the byte as the high byte.
  - On phase 1 the pixel is assembled as cam = {hi,lo} and written if kept:
    - Write_DATA = {cam[4:0], cam[10:5], cam[15:11]}.
    - Write_EN goes high for 1 cycle.
  - Latency: Write_EN/Write_DATA are registered and appear 1 clk after the registered second byte (2 clks after the pin).
  - Kept pixel: x < SRC_H and y < SRC_V, and when DECIM=1, also x[0]=0 and y[0]=0. x increments per assembled pixel.
  - HREF falling edge: y increments, x and byte phase clear. An odd trailing byte is discarded.
  - Extra pixels (x >= SRC_H) and extra lines (y >= SRC_V) are dropped silently.
  - vs rising edge: pulse Frame_Done; Frame_Err = (pixel counter != OUT_H*OUT_V); go to ARMED. The next vs falling edge starts the next frame, so capture is continuous.
- Simultaneous events: a vs rising edge while HREF is high ends the frame. Bytes in that cycle are not written.
- Write_EN never asserts outside ACTIVE.
- The pixel counter is 20 bits and saturates at all-ones.
- Reset mid-frame: outputs clear immediately (async). Capture resumes only via WAIT_SYNC and SKIP.

Test Plan:
- Reset, SKIP_FRAMES=2, DECIM=1, five 640x480 frames of ramp data:
  - No Write_EN during the first two complete frames.
  - Frames 3-5 each give exactly one Frame_Start, 76800 Write_EN and one Frame_Done with Frame_Err=0.
- Byte pair 0xF8,0x1F (cam=0xF81F), pixel x=0,y=0 → Write_DATA=0xF81F (R and B swapped, symmetric). Byte pair 0xF8,0x00 → Write_DATA=0x001F, Write_EN exactly 2 clks after the second byte.
- DECIM=1 line with 640 pixels → 320 writes carrying source pixels 0,2,4,...; the odd line that follows gives 0 writes.
- Line with 641 bytes (odd trailing byte), then a 650-pixel line → the partial byte is discarded, pixels past 639 are dropped, and the next line starts at phase 0.
- Frame truncated to 200 lines → Frame_Done pulses, Frame_Err=1, and the next full frame clears Frame_Err=0.
- rst asserted mid-line in ACTIVE → Write_EN=0 and Capturing=0 asynchronously. After release, no writes until WAIT_SYNC and SKIP complete.

Source files
------------

// File: rtl/cam_pixel_writer.sv
// OV5640 DVP capture: assembles RGB565 from byte pairs, optionally decimates 2:1 in X/Y,
// and drives one SDRAM write port. Everything runs on the camera pixel clock.
module cam_pixel_writer #(
  parameter int SRC_H       = 640,
  parameter int SRC_V       = 480,
  parameter int DECIM       = 1,
  parameter int SKIP_FRAMES = 10,
  parameter int VS_POL      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CAM_VSYNC,
  input  logic        CAM_HREF,
  input  logic [7:0]  CAM_DATA,
  output logic [15:0] Write_DATA,
  output logic        Write_EN,
  output logic        Frame_Start,
  output logic        Frame_Done,
  output logic        Frame_Err,
  output logic        Capturing
);

  localparam int          OUT_H    = (DECIM != 0) ? SRC_H / 2 : SRC_H;
  localparam int          OUT_V    = (DECIM != 0) ? SRC_V / 2 : SRC_V;
  localparam logic [19:0] OUT_PIX  = 20'(OUT_H * OUT_V);
  localparam int          XW       = $clog2(SRC_H + 1) + 1;
  localparam int          YW       = $clog2(SRC_V + 1) + 1;
  localparam logic        VS_POL_B = (VS_POL != 0);
  localparam logic [7:0]  SKIP_N   = 8'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    SKIP,
    ARMED,
    ACTIVE
  } state_t;

  state_t state;

  logic          vs_q, vs_d, href_q, href_d;
  logic [7:0]    data_q;
  logic          vs_rise, vs_fall, href_fall;
  logic [7:0]    skip_cnt;
  logic          phase;
  logic [7:0]    hi_byte;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [19:0]   pix_cnt;
  logic [15:0]   cam;
  logic          keep;

  // One input register stage; vs is normalised so that 1 always means blanking.
  // The sync history resets to "active" so a sensor already in blanking at reset
  // shows up as a rising edge, never as a spurious frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q   <= 1'b0;
      vs_d   <= 1'b0;
      href_q <= 1'b0;
      href_d <= 1'b0;
      data_q <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values,
      // so vs_d really is the previous vs_q regardless of statement order.
      vs_q   <= ~(CAM_VSYNC ^ VS_POL_B);
      vs_d   <= vs_q;
      href_q <= CAM_HREF;
      href_d <= href_q;
      data_q <= CAM_DATA;
    end
  end

  assign vs_rise   = vs_q & ~vs_d;
  assign vs_fall   = ~vs_q & vs_d;
  assign href_fall = ~href_q & href_d;
  assign cam       = {hi_byte, data_q};

  always_comb begin
    // NOTE: assign a default before any conditional update so no path leaves keep
    // unassigned, which would otherwise infer a latch.
    keep = (x < XW'(SRC_H)) && (y < YW'(SRC_V));
    if (DECIM != 0) begin
      keep = keep && !x[0] && !y[0];
    end
  end

  // Control and datapath share one block so every output is a registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_SYNC;
      skip_cnt    <= 8'd0;
      phase       <= 1'b0;
      hi_byte     <= 8'h00;
      x           <= '0;
      y           <= '0;
      pix_cnt     <= 20'd0;
      Write_DATA  <= 16'h0000;
      Write_EN    <= 1'b0;
      Frame_Start <= 1'b0;
      Frame_Done  <= 1'b0;
      Frame_Err   <= 1'b0;
      Capturing   <= 1'b0;
    end else begin
      Write_EN    <= 1'b0;
      Frame_Start <= 1'b0;
      Frame_Done  <= 1'b0;

      case (state)
        WAIT_SYNC: begin
          if (vs_fall) begin
            skip_cnt <= 8'd0;
            state    <= (SKIP_N == 8'd0) ? ARMED : SKIP;
          end
        end

        SKIP: begin
          if (vs_rise) begin
            skip_cnt <= skip_cnt + 8'd1;
            if (skip_cnt + 8'd1 == SKIP_N) begin
              state <= ARMED;
            end
          end
        end

        ARMED: begin
          if (vs_fall) begin
            Frame_Start <= 1'b1;
            Capturing   <= 1'b1;
            x           <= '0;
            y           <= '0;
            phase       <= 1'b0;
            pix_cnt     <= 20'd0;
            state       <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (vs_rise) begin
            // End of frame wins over any byte arriving in the same cycle.
            Frame_Done <= 1'b1;
            Frame_Err  <= (pix_cnt != OUT_PIX);
            Capturing  <= 1'b0;
            state      <= ARMED;
          end else if (href_q) begin
            if (!phase) begin
              hi_byte <= data_q;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (x != '1) begin
                x <= x + 1'b1;
              end
              if (keep) begin
                Write_EN   <= 1'b1;
                Write_DATA <= {cam[4:0], cam[10:5], cam[15:11]};
                if (pix_cnt != '1) begin
                  pix_cnt <= pix_cnt + 20'd1;
                end
              end
            end
          end else if (href_fall) begin
            // Dropping phase here discards an odd trailing byte.
            x     <= '0;
            phase <= 1'b0;
            if (y != '1) begin
              y <= y + 1'b1;
            end
          end
        end

        default: state <= WAIT_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_pixel_writer.sv
// Directed bench for cam_pixel_writer on a reduced 16x8 source so full frames stay short.
module tb_cam_pixel_writer;

  localparam int H     = 16;
  localparam int V     = 8;
  localparam int OUT_N = (H / 2) * (V / 2);

  logic        clk = 1'b0;
  logic        rst;
  logic        CAM_VSYNC;
  logic        CAM_HREF;
  logic [7:0]  CAM_DATA;
  logic [15:0] Write_DATA;
  logic        Write_EN;
  logic        Frame_Start;
  logic        Frame_Done;
  logic        Frame_Err;
  logic        Capturing;

  int tests = 0;
  int fails = 0;

  int cyc     = 0;
  int fs_cnt  = 0;
  int fd_cnt  = 0;
  int bad_cnt = 0;
  logic [15:0] act_q[$];
  int          wr_cyc_q[$];
  logic [15:0] exp_q[$];
  bit          exp_on = 1'b0;

  cam_pixel_writer #(
    .SRC_H(H), .SRC_V(V), .DECIM(1), .SKIP_FRAMES(2), .VS_POL(1)
  ) dut (
    .clk(clk), .rst(rst),
    .CAM_VSYNC(CAM_VSYNC), .CAM_HREF(CAM_HREF), .CAM_DATA(CAM_DATA),
    .Write_DATA(Write_DATA), .Write_EN(Write_EN),
    .Frame_Start(Frame_Start), .Frame_Done(Frame_Done),
    .Frame_Err(Frame_Err), .Capturing(Capturing)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are observed on the falling edge, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (Write_EN) begin
      act_q.push_back(Write_DATA);
      wr_cyc_q.push_back(cyc);
    end
    if (Frame_Start) fs_cnt <= fs_cnt + 1;
    if (Frame_Done) fd_cnt <= fd_cnt + 1;
    if (Write_EN && !Capturing) bad_cnt <= bad_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] swap565(input logic [15:0] c);
    return {c[4:0], c[10:5], c[15:11]};
  endfunction

  function automatic logic [15:0] ramp(input int y, input int x);
    return 16'((y * 1031) ^ (x * 291) ^ 16'h5A5A);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    CAM_HREF = 1'b1;
    CAM_DATA = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      CAM_HREF = 1'b0;
      CAM_DATA = 8'h00;
    end
  endtask

  task automatic send_pix(input int y, input int x, input logic [15:0] c);
    send_byte(c[15:8]);
    send_byte(c[7:0]);
    if (exp_on && x < H && y < V && (x % 2) == 0 && (y % 2) == 0)
      exp_q.push_back(swap565(c));
  endtask

  task automatic send_line(input int y, input int npix);
    for (int x = 0; x < npix; x++) send_pix(y, x, ramp(y, x));
    idle(4);
  endtask

  task automatic frame_begin();
    @(negedge clk);
    CAM_VSYNC = 1'b0;
    idle(4);
  endtask

  task automatic frame_end();
    @(negedge clk);
    CAM_VSYNC = 1'b1;
    idle(6);
  endtask

  task automatic send_frame(input int nlines);
    frame_begin();
    for (int y = 0; y < nlines; y++) send_line(y, H);
    frame_end();
  endtask

  task automatic check_frame(input string tag, input int fs0, input int fd0, input int a0,
                             input int exp_fs);
    int n;
    n = act_q.size() - a0;
    check($sformatf("%s.starts", tag), fs_cnt - fs0, exp_fs);
    check($sformatf("%s.dones", tag), fd_cnt - fd0, exp_fs);
    check($sformatf("%s.writes", tag), n, exp_q.size());
    if (exp_fs != 0)
      check($sformatf("%s.err", tag), Frame_Err, (exp_q.size() != OUT_N) ? 1 : 0);
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check($sformatf("%s.data[%0d]", tag, i), act_q[a0 + i], exp_q[i]);
  endtask

  initial begin
    int fs0, fd0, a0, l0, c0;
    logic [15:0] w0, w1;

    rst       = 1'b0;
    CAM_VSYNC = 1'b1;
    CAM_HREF  = 1'b0;
    CAM_DATA  = 8'h00;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.wen", Write_EN, 0);
    check("rst.wdata", Write_DATA, 0);
    check("rst.fstart", Frame_Start, 0);
    check("rst.fdone", Frame_Done, 0);
    check("rst.ferr", Frame_Err, 0);
    check("rst.cap", Capturing, 0);
    rst = 1'b0;
    idle(10);

    // Two settling frames are discarded, then capture is continuous.
    for (int f = 1; f <= 5; f++) begin
      fs0 = fs_cnt; fd0 = fd_cnt; a0 = act_q.size();
      exp_q.delete();
      exp_on = (f >= 3);
      send_frame(V);
      check_frame($sformatf("frame%0d", f), fs0, fd0, a0, (f >= 3) ? 1 : 0);
    end
    check("armed.cap", Capturing, 0);

    // Directed frame: colour swap, latency, decimation, odd byte, overlong line.
    fs0 = fs_cnt; fd0 = fd_cnt; a0 = act_q.size();
    exp_q.delete();
    exp_on = 1'b1;
    frame_begin();
    check("dir.cap", Capturing, 1);
    send_pix(0, 0, 16'hF81F);
    send_pix(0, 1, 16'h0000);
    send_pix(0, 2, 16'hF800);
    c0 = cyc;
    idle(4);
    w0 = (act_q.size() > a0)     ? act_q[a0]     : 16'hDEAD;
    w1 = (act_q.size() > a0 + 1) ? act_q[a0 + 1] : 16'hDEAD;
    check("dir.f81f", w0, 16'hF81F);
    check("dir.f800", w1, 16'h001F);
    check("dir.latency", (wr_cyc_q.size() > a0 + 1) ? wr_cyc_q[a0 + 1] - c0 : -1, 2);
    l0 = act_q.size();
    send_line(1, H);
    check("dir.odd_line", act_q.size() - l0, 0);
    l0 = act_q.size();
    send_line(2, H);
    check("dir.even_line", act_q.size() - l0, H / 2);
    send_line(3, H);
    for (int x = 0; x < H; x++) send_pix(4, x, ramp(4, x));
    send_byte(8'hAB);
    idle(4);
    send_line(5, H);
    l0 = act_q.size();
    send_line(6, H + 10);
    check("dir.long_line", act_q.size() - l0, H / 2);
    send_line(7, H);
    frame_end();
    check("dir.cap_end", Capturing, 0);
    check_frame("dir", fs0, fd0, a0, 1);

    // Truncated frame flags an error; the following full frame clears it.
    fs0 = fs_cnt; fd0 = fd_cnt; a0 = act_q.size();
    exp_q.delete();
    send_frame(V / 2);
    check_frame("trunc", fs0, fd0, a0, 1);
    fs0 = fs_cnt; fd0 = fd_cnt; a0 = act_q.size();
    exp_q.delete();
    send_frame(V);
    check_frame("recover", fs0, fd0, a0, 1);

    // Reset in the middle of an active line.
    frame_begin();
    send_pix(0, 0, 16'h1234);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midrst.pre_wen", Write_EN, 1);
    check("midrst.pre_cap", Capturing, 1);
    rst = 1'b1;
    #1;
    check("midrst.wen", Write_EN, 0);
    check("midrst.cap", Capturing, 0);
    check("midrst.wdata", Write_DATA, 0);
    @(negedge clk);
    rst      = 1'b0;
    CAM_HREF = 1'b0;
    fs0 = fs_cnt; fd0 = fd_cnt; a0 = act_q.size();
    exp_q.delete();
    exp_on = 1'b0;
    idle(4);
    for (int y = 1; y < V; y++) send_line(y, H);
    frame_end();
    send_frame(V);
    send_frame(V);
    check_frame("post_rst_skip", fs0, fd0, a0, 0);
    fs0 = fs_cnt; fd0 = fd_cnt; a0 = act_q.size();
    exp_q.delete();
    exp_on = 1'b1;
    send_frame(V);
    check_frame("post_rst_cap", fs0, fd0, a0, 1);

    check("wen_outside_active", bad_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
